muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle multiply/divide unit holding the architectural HI and LO registers for the single-cycle MIPS core. It sits directly downstream of the datapath register-file read ports: it consumes srca and writedata (rs and rt) on MULT/MULTU/DIV/DIVU, and produces hi/lo for MFHI/MFLO. It replaces the free-running divider plus special-register pair with one start/busy handshake that the controller uses to stall the PC.

## Interface

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  begin operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- srca  in  WIDTH  rs operand (multiplicand / dividend)
- srcb  in  WIDTH  rt operand (multiplier / divisor)
- mthi  in  1  write srca into HI (IDLE only)
- mtlo  in  1  write srca into LO (IDLE only)
- busy  out  1  operation in progress; controller stalls while high
- hi  out  WIDTH  HI register (product high half / remainder)
- lo  out  WIDTH  LO register (product low half / quotient)

## Operation

- States: IDLE, RUN, FIX.
- IDLE: on start=1, latch |srca|, |srcb| (magnitudes for MULT/DIV, raw for MULTU/DIVU) and result signs, clear the accumulator, load the iteration counter with WIDTH, and go to RUN.
- RUN, multiply: shift-add, one multiplier bit per cycle, LSB first, into a 2*WIDTH accumulator.
- RUN, divide: restoring division, one quotient bit per cycle, MSB first. Partial remainder is WIDTH+1 bits.
- RUN: the counter decrements each cycle. At count 1 go to FIX.
- FIX: apply the sign fix-up.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: quotient is negative iff the signs differ. Remainder takes the dividend's sign.
  - FIX writes hi/lo and returns to IDLE.
- Divide by zero (srcb=0, DIV or DIVU): runs the full latency. Result is LO=32'hFFFFFFFF, HI=srca (unsigned algorithm result, then sign fix-up for DIV).
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- mthi/mtlo in IDLE with start=0: write srca to HI/LO at the clock edge. Both may be asserted together.
- start and mthi/mtlo asserted together in IDLE: start wins, and the mt writes are dropped.
- start, mthi and mtlo while busy: ignored. hi/lo stay stable.
- op values outside the legal set do not exist (2-bit field is fully decoded).

## Timing

- Reset (reset=0, asynchronous):
  - state returns to IDLE and any in-flight operation aborts.
  - busy=0, hi=0, lo=0.
- Start edge E0 (start=1 in IDLE):
  - busy=1 from after E0.
  - RUN occupies edges E1..E32.
  - FIX at E33 updates hi/lo; busy=0 after E33.
- Latency: 33 cycles from start edge to valid results.
  - start may be reasserted in the cycle after busy falls; that is a back-to-back issue.
- hi/lo keep their previous values throughout RUN. They change only at the FIX edge, at an mthi/mtlo edge, or at reset.
- Outputs are registered; there is no combinational path from inputs to busy, hi or lo.
- Operands are captured at E0. Later changes on srca, srcb or op have no effect.

## Test plan

- Reset: reset=0 mid-RUN (10 cycles after start) -> busy=0 and hi=lo=0 immediately. A new start after release gives the correct result 33 cycles later.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, busy high exactly 33 cycles.
- MULT -3 * 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIVU 100 / 7 -> LO=14, HI=2.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5.
- Handshake:
  - mtlo with srca=0x1234 in IDLE -> LO=0x1234 next edge.
  - Simultaneous start+mthi -> HI not written by mthi.
  - start, mtlo pulses while busy -> ignored, hi/lo unchanged until FIX.
  - Back-to-back start the cycle after busy falls -> accepted.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MIPS multiply/divide unit owning the HI/LO registers.
// Shift-add multiply (LSB first) and restoring divide (MSB first), one bit per cycle, then a sign fix-up.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t             state;
    logic               is_div, neg_q, neg_r;
    logic [WIDTH-1:0]   a, b;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               sgn, sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     msum, shifted, diff;
    always_comb begin
        sgn     = ~op[0];
        sa      = sgn & srca[WIDTH-1];
        sb      = sgn & srcb[WIDTH-1];
        mag_a   = sa ? -srca : srca;
        mag_b   = sb ? -srcb : srcb;
        msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, a & {WIDTH{b[0]}}};
        shifted = {acc[WIDTH-1:0], a[WIDTH-1]};
        diff    = shifted - {1'b0, b};
    end
    // Multiply: a = multiplicand, b = multiplier shifting right, acc = product.
    // Divide:   a = dividend shifting left into quotient, b = divisor, acc[WIDTH-1:0] = remainder.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a      <= mag_a;
                        b      <= mag_b;
                        acc    <= '0;
                        cnt    <= CW'(WIDTH);
                        is_div <= op[1];
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        if (mthi) hi <= srca;
                        if (mtlo) lo <= srca;
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIX;
                    if (is_div) begin
                        a                <= {a[WIDTH-2:0], ~diff[WIDTH]};
                        acc[WIDTH-1:0]   <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    end else begin
                        acc <= {msum, acc[WIDTH-1:1]};
                        b   <= b >> 1;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        lo <= neg_q ? -a : a;
                        hi <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    end else begin
                        {hi, lo} <= neg_q ? -acc : acc;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed table, handshake sequences and random ops against an arithmetic reference model.
module tb_muldiv_unit;
    logic        clk, reset, start, mthi, mtlo, busy;
    logic [1:0]  op;
    logic [31:0] srca, srcb, hi, lo;
    int checks = 0, errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  o;
        logic [31:0] x, y, eh, el;
        string       nm;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV signed division truncates toward zero with remainder taking the dividend's sign.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        case (o)
            2'd0: return 64'(sx * sy);
            2'd1: return {32'h0, x} * {32'h0, y};
            2'd2: return (y == 0) ? {x, (x[31] ? 32'h1 : 32'hFFFFFFFF)} : {32'(sx % sy), 32'(sx / sy)};
            default: return (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
        endcase
    endfunction

    // Issues one op at a negedge, scrambles inputs while busy, counts busy cycles, checks hi/lo hold then the result.
    task automatic run_and_check(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [63:0] exp, input string nm, input bit mt, input bit poke);
        logic [31:0] h0, l0;
        int n;
        bit stable;
        h0 = hi;
        l0 = lo;
        op = o; srca = x; srcb = y; start = 1'b1; mthi = mt; mtlo = mt;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'($urandom); srca = $urandom; srcb = $urandom;
        n = 0;
        stable = 1'b1;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (hi !== h0 || lo !== l0) stable = 1'b0;
            if (poke && n == 5) begin start = 1'b1; mthi = 1'b1; mtlo = 1'b1; srca = 32'hDEAD_BEEF; end
            if (poke && n == 6) begin start = 1'b0; mthi = 1'b0; mtlo = 1'b0; end
            @(negedge clk);
        end
        chk({nm, "_busy_cycles"}, 64'(n), 64'd33);
        chk({nm, "_hold"}, 64'(stable), 64'd1);
        chk({nm, "_hilo"}, {hi, lo}, exp);
    endtask

    vec_t vt[$];

    initial begin
        start = 0; mthi = 0; mtlo = 0; op = 0; srca = 0; srcb = 0;
        reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 0);
        chk("reset_hilo", {hi, lo}, 0);
        reset = 1'b1;
        @(negedge clk);

        vt.push_back('{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"});
        vt.push_back('{2'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg"});
        vt.push_back('{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minmin"});
        vt.push_back('{2'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg"});
        vt.push_back('{2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_negdivisor"});
        vt.push_back('{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow"});
        vt.push_back('{2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       "divu_100_7"});
        vt.push_back('{2'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, "divu_by_zero"});
        foreach (vt[i]) run_and_check(vt[i].o, vt[i].x, vt[i].y, {vt[i].eh, vt[i].el}, vt[i].nm, 1'b0, 1'b0);

        srca = 32'h1234; mtlo = 1'b1;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo", 64'(lo), 64'h1234);
        srca = 32'hAAAA; mthi = 1'b1; mtlo = 1'b1;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthi_mtlo", {hi, lo}, {32'hAAAA, 32'hAAAA});

        run_and_check(2'd1, 32'd6, 32'd9, 64'd54, "start_mthi", 1'b1, 1'b0);
        run_and_check(2'd3, 32'd1000, 32'd33, {32'd10, 32'd30}, "busy_poke", 1'b0, 1'b1);
        run_and_check(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1, "back_to_back", 1'b0, 1'b0);

        srca = 32'd77; srcb = 32'd3; op = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrun_reset_busy", 64'(busy), 0);
        chk("midrun_reset_hilo", {hi, lo}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_and_check(2'd3, 32'd77, 32'd3, {32'd2, 32'd25}, "after_reset", 1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            logic [1:0]  o;
            logic [31:0] x, y;
            o = 2'($urandom);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'h0;
                1: y = 32'($urandom_range(1, 20));
                2: x = 32'h80000000;
                3: y = 32'hFFFFFFFF;
                default: ;
            endcase
            run_and_check(o, x, y, model(o, x, y), $sformatf("rand%0d_op%0d", i, o), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
